// File: rtl/fetch_if.sv
// Fetch unit control/bus interface.
// Redirect, stall and halt inputs plus the instruction-slot outputs.
interface fetch_if;
  logic        stall;
  logic        halt;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        exc_redirect;
  logic [31:0] exc_target;
  logic [31:0] mem_addr;
  logic [31:0] pc_out;
  logic        bubble_out;
  logic [7:0]  exc_out;
  logic [31:0] fetch_count;

  modport master (
    input  stall, halt,
    input  br_redirect, br_target,
    input  exc_redirect, exc_target,
    output mem_addr, pc_out,
    output bubble_out, exc_out,
    output fetch_count
  );

  modport slave (
    output stall, halt,
    output br_redirect, br_target,
    output exc_redirect, exc_target,
    input  mem_addr, pc_out,
    input  bubble_out, exc_out,
    input  fetch_count
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: PC register, redirects, halt/stall.
// Synchronous imem, so a slot's pc_out trails mem_addr by one cycle.
module fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0400,
  parameter logic [7:0]  MISALIGN_EXC = 8'h82
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clk_en,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        bub_q, bub_d;
  logic [7:0]  exc_q, exc_d;
  logic [31:0] cnt_q, cnt_d;

  assign bus.mem_addr    = pc_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.bubble_out  = bub_q;
  assign bus.exc_out     = exc_q;
  assign bus.fetch_count = cnt_q;

  // State and slot registers; reset forces the power-on slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      bub_q    <= 1'b1;
      exc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      bub_q    <= bub_d;
      exc_q    <= exc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: exc > halt-freeze > branch > stall > sequential.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    bub_d    = bub_q;
    exc_d    = exc_q;
    cnt_d    = cnt_q;
    if (clk_en) begin
      unique case (state_q)
        BOOT: state_d = RUN;
        default: begin
          if (bus.exc_redirect) begin
            state_d = RUN;
            pc_d    = bus.exc_target;
            bub_d   = 1'b1;
            exc_d   = '0;
          end else if (bus.halt) begin
            state_d = HALTED;
          end else if (bus.br_redirect) begin
            state_d = RUN;
            pc_d    = bus.br_target;
            bub_d   = 1'b1;
            exc_d   = '0;
          end else begin
            state_d = RUN;
            if (!bus.stall) begin
              pc_out_d = pc_q;
              bub_d    = 1'b0;
              cnt_d    = cnt_q + 32'd1;
              if (|pc_q[1:0]) begin
                exc_d = MISALIGN_EXC;
              end else begin
                exc_d = '0;
                pc_d  = pc_q + 32'd4;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Testbench for the fetch stage.
// Vector table driven through an expectation queue.
module tb_fetch;

  typedef struct {
    logic        en;
    logic        stall;
    logic        halt;
    logic        br;
    logic [31:0] bt;
    logic        exc;
    logic [31:0] et;
    logic [31:0] ma;
    logic [31:0] po;
    logic        bub;
    logic [7:0]  ex;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [31:0] ma;
    logic [31:0] po;
    logic        bub;
    logic [7:0]  ex;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl[$];
  vec_t boot_tbl[$];
  exp_t sb[$];

  fetch_if bus ();

  fetch #(
    .RESET_PC    (32'h0000_0400),
    .MISALIGN_EXC(8'h82)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_en(clk_en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic en, input logic st, input logic hl,
    input logic br, input logic [31:0] bt,
    input logic ex_r, input logic [31:0] et,
    input logic [31:0] ma, input logic [31:0] po,
    input logic bub, input logic [7:0] ex,
    input logic [31:0] cnt);
    vec_t v;
    v = '{en, st, hl, br, bt, ex_r, et, ma, po, bub, ex, cnt};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    clk_en = 1'b1;
    bus.stall = 1'b0;
    bus.halt = 1'b0;
    bus.br_redirect = 1'b0;
    bus.br_target = '0;
    bus.exc_redirect = 1'b0;
    bus.exc_target = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mem_addr"}, bus.mem_addr, 32'h400);
    chk({tag, ".pc_out"}, bus.pc_out, 32'h0);
    chk({tag, ".bubble"}, {31'd0, bus.bubble_out}, 32'd1);
    chk({tag, ".exc"}, {24'd0, bus.exc_out}, 32'd0);
    chk({tag, ".count"}, bus.fetch_count, 32'd0);
  endtask

  // Called just after a negedge; returns just after the next one.
  task automatic step(input string tag, input int idx, input vec_t v);
    exp_t e;
    string nm;
    clk_en = v.en;
    bus.stall = v.stall;
    bus.halt = v.halt;
    bus.br_redirect = v.br;
    bus.br_target = v.bt;
    bus.exc_redirect = v.exc;
    bus.exc_target = v.et;
    sb.push_back('{v.ma, v.po, v.bub, v.ex, v.cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    nm = $sformatf("%s[%0d]", tag, idx);
    chk({nm, ".mem_addr"}, bus.mem_addr, e.ma);
    chk({nm, ".pc_out"}, bus.pc_out, e.po);
    chk({nm, ".bubble"}, {31'd0, bus.bubble_out}, {31'd0, e.bub});
    chk({nm, ".exc"}, {24'd0, bus.exc_out}, {24'd0, e.ex});
    chk({nm, ".count"}, bus.fetch_count, e.cnt);
    @(negedge clk);
  endtask

  initial begin
    // en st hl br bt  exc et  | mem_addr pc_out bub exc cnt
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h400, 32'h0,   1, 8'h0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h404, 32'h400, 0, 8'h0, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h408, 32'h404, 0, 8'h0, 2));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h40C, 32'h408, 0, 8'h0, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h410, 32'h40C, 0, 8'h0, 4));
    tbl.push_back(mk(1,0,0,1,32'h800,0,0, 32'h800, 32'h40C, 1, 8'h0, 4));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h804, 32'h800, 0, 8'h0, 5));
    tbl.push_back(mk(1,1,0,1,32'h420,0,0, 32'h420, 32'h800, 1, 8'h0, 5));
    tbl.push_back(mk(1,1,0,0,0,0,0, 32'h420, 32'h800, 1, 8'h0, 5));
    tbl.push_back(mk(1,1,0,0,0,0,0, 32'h420, 32'h800, 1, 8'h0, 5));
    tbl.push_back(mk(1,1,0,0,0,0,0, 32'h420, 32'h800, 1, 8'h0, 5));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h424, 32'h420, 0, 8'h0, 6));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h428, 32'h424, 0, 8'h0, 7));
    tbl.push_back(mk(1,1,0,1,32'h900,1,32'h4, 32'h4, 32'h424, 1, 8'h0, 7));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h8, 32'h4, 0, 8'h0, 8));
    tbl.push_back(mk(1,0,0,1,32'h802,0,0, 32'h802, 32'h4, 1, 8'h0, 8));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h802, 32'h802, 0, 8'h82, 9));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h802, 32'h802, 0, 8'h82, 10));
    tbl.push_back(mk(1,0,0,0,0,1,32'h4, 32'h4, 32'h802, 1, 8'h0, 10));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h8, 32'h4, 0, 8'h0, 11));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'hC, 32'h8, 0, 8'h0, 12));
    tbl.push_back(mk(1,0,1,0,0,0,0, 32'hC, 32'h8, 0, 8'h0, 12));
    tbl.push_back(mk(1,0,1,1,32'h100,0,0, 32'hC, 32'h8, 0, 8'h0, 12));
    tbl.push_back(mk(1,0,1,0,0,1,32'h8, 32'h8, 32'h8, 1, 8'h0, 12));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'hC, 32'h8, 0, 8'h0, 13));
    tbl.push_back(mk(0,0,0,1,32'h500,0,0, 32'hC, 32'h8, 0, 8'h0, 13));
    tbl.push_back(mk(0,0,0,0,0,1,32'h600, 32'hC, 32'h8, 0, 8'h0, 13));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h10, 32'hC, 0, 8'h0, 14));
    tbl.push_back(mk(1,0,0,1,32'hFFFF_FFFC,0,0,
                     32'hFFFF_FFFC, 32'hC, 1, 8'h0, 14));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h0, 32'hFFFF_FFFC, 0, 8'h0, 15));
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h4, 32'h0, 0, 8'h0, 16));

    boot_tbl.push_back(mk(1,0,0,0,0,0,0, 32'h400, 32'h0,   1, 8'h0, 0));
    boot_tbl.push_back(mk(1,0,0,0,0,0,0, 32'h404, 32'h400, 0, 8'h0, 1));
    boot_tbl.push_back(mk(1,0,0,0,0,0,0, 32'h408, 32'h404, 0, 8'h0, 2));

    drive_idle();
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    foreach (tbl[i]) step("main", i, tbl[i]);

    // Asynchronous reset in the middle of a stalled redirect.
    bus.stall = 1'b1;
    bus.br_redirect = 1'b1;
    bus.br_target = 32'h700;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(posedge clk);
    #1;
    chk_reset("held");
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    foreach (boot_tbl[i]) step("reboot", i, boot_tbl[i]);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: got %0d left expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0400, first fetch address after reset.
REQ-002 SHALL have parameter MISALIGN_EXC, 8'h82, exception code for a misaligned fetch address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clk_en  input  1  global enable; state changes only when high, except reset.
REQ-006 stall  input  1  downstream stall; hold fetch state.
REQ-007 halt  input  1  core halted; freeze fetch.
REQ-008 br_redirect  input  1  taken branch/jump resolved downstream.
REQ-009 br_target  input  32  branch destination.
REQ-010 exc_redirect  input  1  exception, interrupt or rfe/rfi committed in writeback.
REQ-011 exc_target  input  32  handler address or return epc.
REQ-012 mem_addr  output  32  instruction memory read address; synchronous memory, data valid one cycle later.
REQ-013 pc_out  output  32  address of the instruction whose data arrives this cycle.
REQ-014 bubble_out  output  1  high when the arriving instruction word is invalid.
REQ-015 exc_out  output  8  fetch exception for the arriving slot; 0 = none.
REQ-016 fetch_count  output  32  count of valid, non-bubble slots delivered.

Function
REQ-017 SHALL hold fetch PC register pc; mem_addr SHALL equal pc combinationally.
REQ-018 SHALL implement FSM states BOOT, RUN, HALTED; BOOT SHALL last exactly one enabled cycle after reset, then go to RUN.
REQ-019 In BOOT: pc holds RESET_PC, bubble_out stays 1, pc_out/exc_out unchanged.
REQ-020 In RUN, enabled, no stall, no redirect: pc_out <= pc, pc <= pc+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), bubble_out <= 0, exc_out <= 0.
REQ-021 Redirect priority SHALL be exc_redirect > br_redirect > stall > sequential.
REQ-022 On exc_redirect: pc <= exc_target, bubble_out <= 1, exc_out <= 0; applies even when stall or halt is high, and a HALTED FSM SHALL return to RUN.
REQ-023 On br_redirect without exc_redirect: pc <= br_target, bubble_out <= 1, exc_out <= 0; applies even when stall is high; ignored while halt is high.
REQ-024 Redirect latency SHALL be one cycle: mem_addr = target in the cycle after the redirect edge; target's pc_out with bubble_out=0 one cycle later.
REQ-025 On stall with no redirect: pc, pc_out, bubble_out, exc_out, fetch_count SHALL hold.
REQ-026 On halt with no exc_redirect: FSM SHALL enter HALTED and all outputs hold; when halt drops, the FSM returns to RUN, resuming from held pc.
REQ-027 Misaligned fetch: when pc[1:0] != 0 in a sequential advance, the delivered slot SHALL have pc_out = pc, bubble_out = 0, exc_out = MISALIGN_EXC; pc SHALL hold, not advance, until a redirect.
REQ-028 fetch_count SHALL increment by 1 (wrapping) on each enabled edge that sets bubble_out <= 0; never on bubbles, stalls or halts.
REQ-029 When clk_en is low, all state SHALL hold, including redirects, which are ignored.

Reset
REQ-030 rst_n low SHALL immediately set pc = RESET_PC, pc_out = 0, bubble_out = 1, exc_out = 0, fetch_count = 0, FSM = BOOT.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL override all inputs; the release sequence SHALL be identical to power-on.

Verification
REQ-032 Release reset, no stall: mem_addr 400, 400, 404, 408; pc_out 400, 404 with bubble_out 0 from cycle 3; fetch_count 1, 2.
REQ-033 Running at pc 410, br_redirect, br_target 800 -> next cycle mem_addr 800, bubble_out 1; following cycle pc_out 800, bubble_out 0.
REQ-034 br_redirect to 900 with exc_redirect to 4 in the same cycle while stall is high -> mem_addr 4, bubble_out 1; 900 is never fetched.
REQ-035 stall held 3 cycles at pc 420 -> mem_addr, pc_out, fetch_count unchanged; after release, sequence resumes 424.
REQ-036 br_target 802 -> slot pc_out 802, exc_out 82; pc stuck at 802 until exc_redirect to 4 clears exc_out to 0.
REQ-037 halt high, then exc_redirect to 8 -> FSM leaves HALTED, mem_addr 8; pulse rst_n low mid-run -> outputs at reset values asynchronously.
